rps_match_judge: RTL and testbench
==================================

Name: rps_match_judge

Overview:
- Per-round front end of the rock-paper-scissors game; sits directly upstream of scoreupdate and drives its matchresult input.
- Synchronises the three player buttons, accepts exactly one move per round and draws a CPU move.
- Holds both moves for a reveal period, then emits a one-cycle matchresult code that scoreupdate counts exactly once.

Parameters:
- REVEAL_CYCLES, 4, cycles both moves are shown before the result pulse; legal range 1..255.
- LFSR_SEED, 8'hA5, reset value of the CPU LFSR; must be non-zero.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- btn_rock  input  1  raw button, asynchronous to clk.
- btn_paper  input  1  raw button, asynchronous to clk.
- btn_scissors  input  1  raw button, asynchronous to clk.
- game_over  input  1  from score logic; blocks the start of new rounds.
- cpu_force_en  input  1  test/debug mode: take the CPU move from cpu_force_move.
- cpu_force_move  input  2  forced CPU move; must be 01/10/11 when cpu_force_en=1.
- matchresult  output  2  one-cycle result code to scoreupdate.
- player_move  output  2  latched player move.
- cpu_move  output  2  latched CPU move.
- move_valid  output  1  moves on player_move/cpu_move are current-round.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: all outputs 0; FSM=IDLE; sync flops 0; LFSR=LFSR_SEED; mod-3 counter=01.
- Move encoding: 00 none, 01 rock, 10 paper, 11 scissors.
- matchresult encoding: 00 no event, 01 draw, 10 player win, 11 player lose.
- Button synchronisation:
  - Each button passes through 2-flop sync s1->s2, plus history flop s3.
  - Press edge = s2 & ~s3.
  - A button high at sampling edge k gives its edge in the cycle after edge k+1.
- Valid press: exactly one press edge this cycle and the other two s2 levels low. Anything else is ignored.
- CPU move source:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle.
  - A mod-3 counter cycles 01->10->11->01 on each cycle where lfsr[0]=1.
  - CPU move = counter value, or cpu_force_move if cpu_force_en=1, sampled in the accept cycle.
- FSM states: IDLE, REVEAL, RESULT, WAIT_RELEASE.
  - IDLE -> REVEAL on a valid press with game_over=0. Same edge: latch player_move and cpu_move.
  - REVEAL lasts exactly REVEAL_CYCLES cycles (8-bit down-counter), then -> RESULT.
  - RESULT lasts 1 cycle. matchresult = computed code, registered from the latched moves.
  - RESULT -> WAIT_RELEASE.
  - WAIT_RELEASE -> IDLE when all three s2 levels are 0.
- Latency: button high at edge k -> REVEAL from edge k+2 -> matchresult nonzero for 1 cycle starting edge k+2+REVEAL_CYCLES.
- matchresult is 00 in every state except RESULT.
- Win rule: player wins for (01,11), (10,01), (11,10); equal moves give draw; all other pairs give lose.
- move_valid = 1 in REVEAL, RESULT, WAIT_RELEASE. player_move/cpu_move hold their values until the next accept or reset.
- busy = (state != IDLE).
- game_over is sampled only in IDLE; a round already in progress completes and emits its result.
- Held button: no repeat rounds; a new round needs release then a fresh press.
- Reset mid-round: immediate return to IDLE with all outputs 0; no matchresult pulse is emitted.

Decomposition:
- Shared package rps_pkg holds:
  - move constants MOVE_NONE/ROCK/PAPER/SCISSORS;
  - result constants RES_NONE/DRAW/WIN/LOSE;
  - FSM state encoding.
- Pure function judge(player, cpu) returns the result code; shared with scoreupdate checks.
- One sub-module: btn_sync_edge, 2-flop sync plus edge detect per button, instantiated 3x.

Test Plan:
- Reset: hold resetn=0 for 20ns with buttons toggling -> all outputs 0, busy=0, no matchresult pulse.
- Paper vs rock: cpu_force_en=1, cpu_force_move=01; btn_paper pulse high, held 3 cycles.
  - Required: player_move=10, cpu_move=01.
  - matchresult=10 for exactly 1 cycle, 6 edges after the first sampling edge (REVEAL_CYCLES=4).
- Full matrix: all 9 forced player/CPU pairs -> draws give 01, wins per the win rule give 10, the rest 11.
  - Scoreupdate connected: win/lose/round counts match the number of pulses.
- Ignored presses:
  - rock+paper pressed the same cycle -> stays IDLE, matchresult stays 00.
  - Button held 50 cycles -> exactly one pulse.
  - Press while busy -> ignored.
- game_over: asserted during REVEAL -> that round's result is still emitted. A later press with game_over=1 -> no REVEAL, busy=0.
- Reset mid-round: resetn low in cycle 2 of REVEAL -> IDLE immediately, move_valid=0, no pulse. The next valid press works normally.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared move/result encodings, FSM state type and the judging function.
package rps_pkg;

  localparam int unsigned MOVE_W = 2;

  localparam logic [MOVE_W-1:0] MOVE_NONE     = 2'b00;
  localparam logic [MOVE_W-1:0] MOVE_ROCK     = 2'b01;
  localparam logic [MOVE_W-1:0] MOVE_PAPER    = 2'b10;
  localparam logic [MOVE_W-1:0] MOVE_SCISSORS = 2'b11;

  localparam logic [MOVE_W-1:0] RES_NONE = 2'b00;
  localparam logic [MOVE_W-1:0] RES_DRAW = 2'b01;
  localparam logic [MOVE_W-1:0] RES_WIN  = 2'b10;
  localparam logic [MOVE_W-1:0] RES_LOSE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_REVEAL       = 2'b01,
    ST_RESULT       = 2'b10,
    ST_WAIT_RELEASE = 2'b11
  } state_t;

  // Result code seen from the player's side for one pair of legal moves.
  function automatic logic [MOVE_W-1:0] judge(input logic [MOVE_W-1:0] player,
                                              input logic [MOVE_W-1:0] cpu);
    logic [MOVE_W-1:0] res;
    res = RES_LOSE;
    if (player == cpu)
      res = RES_DRAW;
    else if ((player == MOVE_ROCK     && cpu == MOVE_SCISSORS) ||
             (player == MOVE_PAPER    && cpu == MOVE_ROCK)     ||
             (player == MOVE_SCISSORS && cpu == MOVE_PAPER))
      res = RES_WIN;
    return res;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus history flop and rising-edge detect for one button.
module btn_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic press_c
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain; s3 remembers the previous synchronised level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level   = s2;
  assign press_c = s2 & ~s3;

endmodule

// File: rtl/rps_match_judge.sv
// Per-round front end: accepts one player move, draws a CPU move, reveals, then pulses the result.
module rps_match_judge
  import rps_pkg::*;
#(
  parameter int unsigned REVEAL_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_rock,
  input  logic       btn_paper,
  input  logic       btn_scissors,
  input  logic       game_over,
  input  logic       cpu_force_en,
  input  logic [1:0] cpu_force_move,
  output logic [1:0] matchresult,
  output logic [1:0] player_move,
  output logic [1:0] cpu_move,
  output logic       move_valid,
  output logic       busy
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LFSR_W = 8;

  logic lvl_r, lvl_p, lvl_s;
  logic prs_r, prs_p, prs_s;

  btn_sync_edge u_sync_rock (
    .clk(clk), .resetn(resetn), .btn(btn_rock),     .level(lvl_r), .press_c(prs_r)
  );
  btn_sync_edge u_sync_paper (
    .clk(clk), .resetn(resetn), .btn(btn_paper),    .level(lvl_p), .press_c(prs_p)
  );
  btn_sync_edge u_sync_scissors (
    .clk(clk), .resetn(resetn), .btn(btn_scissors), .level(lvl_s), .press_c(prs_s)
  );

  logic              valid_c;
  logic [MOVE_W-1:0] press_move_c;
  logic              any_level_c;

  // A press counts only when it is the single active button this cycle.
  always_comb begin
    valid_c      = 1'b0;
    press_move_c = MOVE_NONE;
    if (prs_r && !lvl_p && !lvl_s) begin
      valid_c      = 1'b1;
      press_move_c = MOVE_ROCK;
    end else if (prs_p && !lvl_r && !lvl_s) begin
      valid_c      = 1'b1;
      press_move_c = MOVE_PAPER;
    end else if (prs_s && !lvl_r && !lvl_p) begin
      valid_c      = 1'b1;
      press_move_c = MOVE_SCISSORS;
    end
  end

  assign any_level_c = lvl_r | lvl_p | lvl_s;

  logic [LFSR_W-1:0] lfsr;
  logic [MOVE_W-1:0] mod3;

  // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) steering a 1..3 counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
      mod3 <= MOVE_ROCK;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (lfsr[0])
        mod3 <= (mod3 == MOVE_SCISSORS) ? MOVE_ROCK : mod3 + 2'b01;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] reveal_cnt;

  // Round FSM with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      reveal_cnt  <= '0;
      matchresult <= RES_NONE;
      player_move <= MOVE_NONE;
      cpu_move    <= MOVE_NONE;
      move_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          matchresult <= RES_NONE;
          if (valid_c && !game_over) begin
            state       <= ST_REVEAL;
            reveal_cnt  <= CNT_W'(REVEAL_CYCLES - 1);
            player_move <= press_move_c;
            cpu_move    <= cpu_force_en ? cpu_force_move : mod3;
            move_valid  <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_REVEAL: begin
          if (reveal_cnt == '0) begin
            state       <= ST_RESULT;
            matchresult <= judge(player_move, cpu_move);
          end else begin
            reveal_cnt <= reveal_cnt - CNT_W'(1);
          end
        end
        ST_RESULT: begin
          state       <= ST_WAIT_RELEASE;
          matchresult <= RES_NONE;
        end
        ST_WAIT_RELEASE: begin
          if (!any_level_c) begin
            state      <= ST_IDLE;
            move_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          matchresult <= RES_NONE;
          move_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_judge.sv
// Scoreboard bench for rps_match_judge.
module tb_rps_match_judge;

  localparam int unsigned REVEAL = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_rock = 1'b0, btn_paper = 1'b0, btn_scissors = 1'b0;
  logic       game_over = 1'b0;
  logic       cpu_force_en = 1'b0;
  logic [1:0] cpu_force_move = 2'b01;
  logic [1:0] matchresult, player_move, cpu_move;
  logic       move_valid, busy;

  rps_match_judge #(.REVEAL_CYCLES(REVEAL), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .resetn(resetn),
    .btn_rock(btn_rock), .btn_paper(btn_paper), .btn_scissors(btn_scissors),
    .game_over(game_over), .cpu_force_en(cpu_force_en), .cpu_force_move(cpu_force_move),
    .matchresult(matchresult), .player_move(player_move), .cpu_move(cpu_move),
    .move_valid(move_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_win = 0, n_draw = 0, n_lose = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] code;
    logic [1:0] p;
    logic [1:0] c;
    int         at;
  } exp_t;
  exp_t sb[$];

  // Reference CPU-move source built from the LFSR/counter description.
  logic [7:0] m_lfsr;
  logic [1:0] m_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_lfsr <= 8'hA5;
      m_cnt  <= 2'b01;
    end else begin
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (m_lfsr[0]) m_cnt <= (m_cnt == 2'b11) ? 2'b01 : m_cnt + 2'b01;
    end
  end

  function automatic logic [1:0] ref_judge(input logic [1:0] p, input logic [1:0] c);
    if (p == c) return 2'b01;
    if ((p == 2'b01 && c == 2'b11) || (p == 2'b10 && c == 2'b01) || (p == 2'b11 && c == 2'b10))
      return 2'b10;
    return 2'b11;
  endfunction

  // Pop and compare every result pulse against the scoreboard.
  always @(negedge clk) begin
    if (resetn && matchresult !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: matchresult=%b at cycle %0d, none expected", matchresult, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (matchresult !== e.code || cyc != e.at || player_move !== e.p || cpu_move !== e.c) begin
          errors++;
          $display("FAIL result_pulse: got code=%b cyc=%0d p=%b c=%b, want code=%b cyc=%0d p=%b c=%b",
                   matchresult, cyc, player_move, cpu_move, e.code, e.at, e.p, e.c);
        end
      end
      case (matchresult)
        2'b01: n_draw++;
        2'b10: n_win++;
        2'b11: n_lose++;
        default: ;
      endcase
    end
  end

  task automatic set_btn(input logic [1:0] mv);
    btn_rock     = (mv == 2'b01);
    btn_paper    = (mv == 2'b10);
    btn_scissors = (mv == 2'b11);
  endtask

  // Hold one button for 'hold' (>=2) sampling edges; optionally expect a round.
  task automatic press_move(input logic [1:0] p, input int hold, input bit push);
    int c;
    exp_t e;
    @(negedge clk);
    set_btn(p);
    c = cyc;
    @(negedge clk);
    @(negedge clk);
    if (push) begin
      e.p    = p;
      e.c    = cpu_force_en ? cpu_force_move : m_cnt;
      e.code = ref_judge(e.p, e.c);
      e.at   = c + 3 + int'(REVEAL);
      sb.push_back(e);
    end
    repeat (hold - 2) @(negedge clk);
    set_btn(2'b00);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", tag, busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_rock = ~btn_rock;
      btn_paper = (i % 2) == 0;
      #5;
    end
    checks++;
    if (matchresult !== 2'b00 || player_move !== 2'b00 || cpu_move !== 2'b00) begin
      errors++;
      $display("FAIL reset_codes: mr=%b p=%b c=%b, want 00 00 00", matchresult, player_move, cpu_move);
    end
    checks++;
    if (move_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: move_valid=%b busy=%b, want 0 0", move_valid, busy);
    end
    set_btn(2'b00);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || matchresult !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: busy=%b mr=%b, want 0 00", busy, matchresult);
    end
  endtask

  task automatic test_paper_rock;
    cpu_force_en = 1'b1;
    cpu_force_move = 2'b01;
    press_move(2'b10, 3, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (player_move !== 2'b10 || cpu_move !== 2'b01) begin
      errors++;
      $display("FAIL paper_rock_moves: p=%b c=%b, want 10 01", player_move, cpu_move);
    end
    checks++;
    if (move_valid !== 1'b1 || busy !== 1'b1 || matchresult !== 2'b00) begin
      errors++;
      $display("FAIL paper_rock_reveal: mv=%b busy=%b mr=%b, want 1 1 00", move_valid, busy, matchresult);
    end
    wait_idle("paper_rock");
    checks++;
    if (move_valid !== 1'b0 || player_move !== 2'b10) begin
      errors++;
      $display("FAIL paper_rock_after: mv=%b p=%b, want 0 10", move_valid, player_move);
    end
  endtask

  task automatic test_matrix;
    int w0, d0, l0;
    w0 = n_win; d0 = n_draw; l0 = n_lose;
    cpu_force_en = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      for (int c = 1; c <= 3; c++) begin
        cpu_force_move = 2'(c);
        press_move(2'(p), 2, 1);
        wait_idle("matrix");
      end
    end
    checks++;
    if (n_win - w0 != 3 || n_draw - d0 != 3 || n_lose - l0 != 3) begin
      errors++;
      $display("FAIL matrix_counts: win=%0d draw=%0d lose=%0d, want 3 3 3", n_win - w0, n_draw - d0, n_lose - l0);
    end
  endtask

  task automatic test_ignored;
    @(negedge clk);
    btn_rock = 1'b1;
    btn_paper = 1'b1;
    repeat (3) @(negedge clk);
    set_btn(2'b00);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || move_valid !== 1'b0) begin
      errors++;
      $display("FAIL dual_press: busy=%b mv=%b, want 0 0", busy, move_valid);
    end
    cpu_force_move = 2'b10;
    press_move(2'b11, 50, 1);
    wait_idle("held");
    cpu_force_move = 2'b11;
    press_move(2'b01, 2, 1);
    @(negedge clk);
    btn_paper = 1'b1;
    repeat (2) @(negedge clk);
    btn_paper = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (player_move !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_press: p=%b busy=%b, want 01 1", player_move, busy);
    end
    wait_idle("busy_press");
  endtask

  task automatic test_game_over;
    cpu_force_move = 2'b10;
    press_move(2'b11, 2, 1);
    repeat (2) @(negedge clk);
    game_over = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL game_over_reveal: busy=%b, want 1", busy);
    end
    wait_idle("game_over");
    press_move(2'b01, 2, 0);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || move_valid !== 1'b0 || matchresult !== 2'b00) begin
      errors++;
      $display("FAIL game_over_block: busy=%b mv=%b mr=%b, want 0 0 00", busy, move_valid, matchresult);
    end
    game_over = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_round;
    cpu_force_move = 2'b01;
    press_move(2'b10, 2, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: busy=%b, want 1", busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || move_valid !== 1'b0 || player_move !== 2'b00 ||
        cpu_move !== 2'b00 || matchresult !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: busy=%b mv=%b p=%b c=%b mr=%b, want all 0",
               busy, move_valid, player_move, cpu_move, matchresult);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    press_move(2'b10, 2, 1);
    wait_idle("after_reset");
  endtask

  task automatic test_back_to_back;
    cpu_force_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      press_move(2'(1 + (i % 3)), 2, 1);
      wait_idle("lfsr");
      repeat ($urandom_range(0, 7)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_paper_rock();
    test_matrix();
    test_ignored();
    test_game_over();
    test_reset_mid_round();
    test_back_to_back();
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected results never seen, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
